// File: rtl/ysyx_24100012_pkg.sv
// Shared definitions for the ysyx_24100012 instruction fetch path:
// fetch FSM state encoding and default reset PC / PC increment.
package ysyx_24100012_pkg;

   localparam int unsigned FETCH_WORD_SIZE   = 4;
   localparam logic [31:0] FETCH_ORIGIN_ADDR = 32'h8000_0000;

   typedef enum logic [2:0] {
      FS_IDLE,
      FS_REQ,
      FS_WAIT,
      FS_DROP,
      FS_HALT
   } fetch_state_e;

endpackage

// File: rtl/ysyx_24100012_sync_fifo.sv
// Single-clock FIFO with synchronous flush; flush overrides push and pop.
// DEPTH must be a power of two so the pointers wrap naturally.
module ysyx_24100012_sync_fifo #(
   parameter int unsigned WIDTH = 64,
   parameter int unsigned DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] head_data
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]   count_q, count_d;
   logic             do_push;
   logic             do_pop;

   assign full      = (count_q == (PTR_W+1)'(DEPTH));
   assign empty     = (count_q == '0);
   assign head_data = mem_q[rd_ptr_q];
   assign do_push   = push && !full;
   assign do_pop    = pop && !empty;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
         end
         if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         count_d = count_q + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q    <= '{default: '0};
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/ysyx_24100012_fetch_unit.sv
// Instruction fetch unit: one outstanding memory request, small instruction
// buffer toward decode, redirect flush with stale-response dropping, sticky halt.
module ysyx_24100012_fetch_unit
   import ysyx_24100012_pkg::*;
#(
   parameter int unsigned           ADDR_WIDTH  = 32,
   parameter int unsigned           DATA_WIDTH  = 32,
   parameter logic [ADDR_WIDTH-1:0] ORIGIN_ADDR = ADDR_WIDTH'(FETCH_ORIGIN_ADDR),
   parameter int unsigned           WORD_SIZE   = FETCH_WORD_SIZE,
   parameter int unsigned           BUF_DEPTH   = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   output logic                  req_valid,
   input  logic                  req_ready,
   output logic [ADDR_WIDTH-1:0] req_addr,
   input  logic                  rsp_valid,
   input  logic [DATA_WIDTH-1:0] rsp_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_inst,
   output logic [ADDR_WIDTH-1:0] out_pc,
   output logic [ADDR_WIDTH-1:0] out_pc_next,
   input  logic                  redirect_valid,
   input  logic [ADDR_WIDTH-1:0] redirect_pc,
   input  logic                  halt,
   output logic                  halted
);

   localparam int unsigned ENTRY_W = DATA_WIDTH + ADDR_WIDTH;

   fetch_state_e          state_q, state_d;
   logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
   logic                  halt_q, halt_d;
   logic                  redir_pend_q, redir_pend_d;
   logic [ADDR_WIDTH-1:0] redir_pc_q, redir_pc_d;

   logic                  buf_push;
   logic                  buf_pop;
   logic                  buf_flush;
   logic                  buf_full;
   logic                  buf_empty;
   logic [ENTRY_W-1:0]    buf_wdata;
   logic [ENTRY_W-1:0]    buf_head;

   assign req_addr  = fetch_pc_q;
   assign buf_wdata = {rsp_data, fetch_pc_q};
   assign out_valid = !buf_empty;
   assign buf_pop   = out_valid && out_ready;

   assign out_inst    = buf_empty ? '0 : buf_head[ENTRY_W-1:ADDR_WIDTH];
   assign out_pc      = buf_empty ? fetch_pc_q : buf_head[ADDR_WIDTH-1:0];
   assign out_pc_next = out_pc + ADDR_WIDTH'(WORD_SIZE);

   always_comb begin
      state_d      = state_q;
      fetch_pc_d   = fetch_pc_q;
      halt_d       = halt_q | halt;
      redir_pend_d = redir_pend_q;
      redir_pc_d   = redir_pc_q;
      req_valid    = 1'b0;
      buf_push     = 1'b0;
      buf_flush    = 1'b0;
      halted       = 1'b0;

      unique case (state_q)
         FS_IDLE: begin
            if (redirect_valid) begin
               buf_flush  = 1'b1;
               fetch_pc_d = redirect_pc;
            end else if (halt_d) begin
               state_d = FS_HALT;
            end else if (!buf_full) begin
               state_d = FS_REQ;
            end
         end

         FS_REQ: begin
            req_valid = 1'b1;
            if (redirect_valid) begin
               buf_flush = 1'b1;
            end
            // An unaccepted request must stay stable, so a redirect seen here is
            // parked and only applied to fetch_pc once the request is taken.
            if (req_ready) begin
               redir_pend_d = 1'b0;
               if (redirect_valid) begin
                  fetch_pc_d = redirect_pc;
                  state_d    = FS_DROP;
               end else if (redir_pend_q) begin
                  fetch_pc_d = redir_pc_q;
                  state_d    = FS_DROP;
               end else begin
                  state_d = FS_WAIT;
               end
            end else if (redirect_valid) begin
               redir_pend_d = 1'b1;
               redir_pc_d   = redirect_pc;
            end
         end

         FS_WAIT: begin
            if (redirect_valid) begin
               buf_flush  = 1'b1;
               fetch_pc_d = redirect_pc;
               state_d    = rsp_valid ? FS_IDLE : FS_DROP;
            end else if (rsp_valid) begin
               buf_push   = 1'b1;
               fetch_pc_d = fetch_pc_q + ADDR_WIDTH'(WORD_SIZE);
               state_d    = FS_IDLE;
            end
         end

         FS_DROP: begin
            if (redirect_valid) begin
               fetch_pc_d = redirect_pc;
            end
            if (rsp_valid) begin
               state_d = FS_IDLE;
            end
         end

         FS_HALT: begin
            halted = 1'b1;
         end

         default: begin
            state_d = FS_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= FS_IDLE;
         fetch_pc_q   <= ORIGIN_ADDR;
         halt_q       <= 1'b0;
         redir_pend_q <= 1'b0;
         redir_pc_q   <= '0;
      end else begin
         state_q      <= state_d;
         fetch_pc_q   <= fetch_pc_d;
         halt_q       <= halt_d;
         redir_pend_q <= redir_pend_d;
         redir_pc_q   <= redir_pc_d;
      end
   end

   ysyx_24100012_sync_fifo #(
      .WIDTH(ENTRY_W),
      .DEPTH(BUF_DEPTH)
   ) u_inst_buf (
      .clk      (clk),
      .rst_n    (rst),
      .flush    (buf_flush),
      .push     (buf_push),
      .push_data(buf_wdata),
      .pop      (buf_pop),
      .full     (buf_full),
      .empty    (buf_empty),
      .head_data(buf_head)
   );

endmodule

// File: tb/tb_ysyx_24100012_fetch_unit.sv
// Scoreboard bench for ysyx_24100012_fetch_unit: a memory model answers
// accepted requests, kept responses are queued and compared at decode pops.
module tb_ysyx_24100012_fetch_unit;

   localparam int unsigned BUF_DEPTH = 2;
   localparam logic [31:0] ORIGIN    = 32'h8000_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req_valid;
   logic        req_ready = 1'b0;
   logic [31:0] req_addr;
   logic        rsp_valid = 1'b0;
   logic [31:0] rsp_data = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_inst;
   logic [31:0] out_pc;
   logic [31:0] out_pc_next;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        halt = 1'b0;
   logic        halted;

   always #5 clk = ~clk;

   ysyx_24100012_fetch_unit #(
      .ADDR_WIDTH (32),
      .DATA_WIDTH (32),
      .ORIGIN_ADDR(ORIGIN),
      .WORD_SIZE  (4),
      .BUF_DEPTH  (BUF_DEPTH)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_addr      (req_addr),
      .rsp_valid     (rsp_valid),
      .rsp_data      (rsp_data),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_inst      (out_inst),
      .out_pc        (out_pc),
      .out_pc_next   (out_pc_next),
      .redirect_valid(redirect_valid),
      .redirect_pc   (redirect_pc),
      .halt          (halt),
      .halted        (halted)
   );

   typedef struct packed {
      logic [31:0] inst;
      logic [31:0] pc;
   } exp_t;

   exp_t        sb[$];
   int unsigned n_cmp = 0;
   int unsigned n_err = 0;

   // stimulus knobs applied at the next step
   logic        k_ready = 1'b1;
   logic        k_oready = 1'b1;
   logic        k_redir = 1'b0;
   logic [31:0] k_redir_pc = '0;
   logic        k_halt = 1'b0;
   int unsigned k_delay = 0;

   // reference model of the fetch stream and the memory
   logic [31:0] exp_pc = ORIGIN;
   logic        pend = 1'b0;
   logic [31:0] pend_pc = '0;
   logic        mem_busy = 1'b0;
   int unsigned mem_cnt = 0;
   logic [31:0] mem_addr = '0;
   logic [31:0] fl_addr = '0;
   logic        fl_taint = 1'b0;
   int unsigned n_acc = 0;
   logic        ok;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'h8000_0013;
   endfunction

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic model_clear();
      sb.delete();
      exp_pc   = ORIGIN;
      pend     = 1'b0;
      mem_busy = 1'b0;
      mem_cnt  = 0;
      fl_taint = 1'b0;
   endtask

   // Called at a falling edge: drive inputs, check, update model for the next rising edge.
   task automatic step();
      logic rsp, acc, pop, keep, busy0;
      exp_t e;
      busy0          = mem_busy;
      rsp            = mem_busy && (mem_cnt == 0);
      rsp_valid      = rsp;
      rsp_data       = rsp ? mem_word(mem_addr) : '0;
      req_ready      = k_ready;
      out_ready      = k_oready;
      redirect_valid = k_redir;
      redirect_pc    = k_redir_pc;
      halt           = k_halt;
      #1;
      chk("out_valid", {63'b0, out_valid}, {63'b0, sb.size() != 0});
      if (sb.size() == BUF_DEPTH) chk("req_when_full", {63'b0, req_valid}, 64'd0);
      if (req_valid) chk("req_addr", {32'b0, req_addr}, {32'b0, exp_pc});
      acc = req_valid && req_ready;
      pop = out_valid && out_ready && !redirect_valid;
      if (pop && sb.size() != 0) begin
         e = sb.pop_front();
         chk("out_inst", {32'b0, out_inst}, {32'b0, e.inst});
         chk("out_pc", {32'b0, out_pc}, {32'b0, e.pc});
         chk("out_pc_next", {32'b0, out_pc_next}, {32'b0, e.pc + 32'd4});
      end
      if (rsp) begin
         keep = !fl_taint && !redirect_valid;
         if (keep) begin
            sb.push_back({mem_word(fl_addr), fl_addr});
            exp_pc = fl_addr + 32'd4;
         end
         mem_busy = 1'b0;
      end else if (busy0 && mem_cnt > 0) begin
         mem_cnt--;
      end
      if (acc) begin
         n_acc++;
         fl_addr  = exp_pc;
         fl_taint = pend || redirect_valid;
         if (pend) begin
            exp_pc = pend_pc;
            pend   = 1'b0;
         end
         mem_busy = 1'b1;
         mem_cnt  = k_delay;
         mem_addr = req_addr;
      end
      if (redirect_valid) begin
         sb.delete();
         if (busy0 && !rsp) fl_taint = 1'b1;
         if (acc || !req_valid) begin
            exp_pc = redirect_pc;
         end else begin
            pend    = 1'b1;
            pend_pc = redirect_pc;
         end
      end
      @(negedge clk);
   endtask

   task automatic do_reset(input int unsigned cycles);
      rst = 1'b0;
      model_clear();
      for (int unsigned i = 0; i < cycles; i++) begin
         step();
         chk("rst_req_valid", {63'b0, req_valid}, 64'd0);
         chk("rst_out_valid", {63'b0, out_valid}, 64'd0);
         chk("rst_halted", {63'b0, halted}, 64'd0);
         chk("rst_out_inst", {32'b0, out_inst}, 64'd0);
         chk("rst_out_pc", {32'b0, out_pc}, {32'b0, ORIGIN});
         chk("rst_out_pc_next", {32'b0, out_pc_next}, {32'b0, ORIGIN + 32'd4});
      end
      rst = 1'b1;
   endtask

   task automatic redirect_once(input logic [31:0] target);
      k_redir    = 1'b1;
      k_redir_pc = target;
      step();
      k_redir    = 1'b0;
   endtask

   initial begin
      @(negedge clk);
      do_reset(3);

      // fill the buffer with decode stalled, then drain
      k_oready = 1'b0;
      n_acc    = 0;
      repeat (12) step();
      chk("fill_accepts", 64'(n_acc), 64'd2);
      chk("full_head_pc", {32'b0, out_pc}, {32'b0, ORIGIN});
      chk("full_head_inst", {32'b0, out_inst}, 64'h13);
      k_oready = 1'b1;
      repeat (8) step();

      // redirect while waiting on a slow response
      k_delay = 3;
      for (int i = 0; i < 30 && !(mem_busy && mem_cnt > 0); i++) step();
      ok = mem_busy && (mem_cnt > 0);
      chk("wait_slow_rsp", {63'b0, ok}, 64'd1);
      redirect_once(32'h8000_0100);
      k_delay = 0;
      repeat (12) step();

      // redirect in the same cycle as the response
      for (int i = 0; i < 30 && !mem_busy; i++) step();
      chk("wait_fast_rsp", {63'b0, mem_busy}, 64'd1);
      redirect_once(32'h8000_0200);
      repeat (10) step();

      // stalled request with redirect in its second cycle, from reset
      do_reset(2);
      k_ready = 1'b0;
      for (int i = 0; i < 10 && !req_valid; i++) step();
      chk("stall_req_seen", {63'b0, req_valid}, 64'd1);
      for (int unsigned i = 0; i < 5; i++) begin
         k_redir    = (i == 1);
         k_redir_pc = 32'h8000_0100;
         step();
      end
      k_redir = 1'b0;
      k_ready = 1'b1;
      repeat (12) step();

      // address wrap at the top of the space
      redirect_once(32'hFFFF_FFFC);
      repeat (12) step();

      // redirect coinciding with a pop from a full buffer
      k_oready = 1'b0;
      repeat (10) step();
      k_oready = 1'b1;
      redirect_once(32'h8000_0300);
      repeat (10) step();

      // halt pulse during an outstanding request
      chk("pre_halt_halted", {63'b0, halted}, 64'd0);
      k_delay = 2;
      for (int i = 0; i < 30 && !(mem_busy && mem_cnt > 0); i++) step();
      ok = mem_busy && (mem_cnt > 0);
      chk("wait_halt_rsp", {63'b0, ok}, 64'd1);
      k_halt = 1'b1;
      step();
      k_halt = 1'b0;
      n_acc  = 0;
      repeat (10) step();
      chk("halted", {63'b0, halted}, 64'd1);
      for (int unsigned i = 0; i < 5; i++) begin
         step();
         chk("halt_no_req", {63'b0, req_valid}, 64'd0);
      end
      chk("halt_accepts", 64'(n_acc), 64'd0);

      // reset while a request is stalled, then resume from the origin
      k_delay = 0;
      do_reset(2);
      k_ready = 1'b0;
      for (int i = 0; i < 10 && !req_valid; i++) step();
      chk("pre_rst_req", {63'b0, req_valid}, 64'd1);
      do_reset(2);
      k_ready = 1'b1;
      repeat (12) step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/ysyx_24100012_fetch_unit.md
YSYX_24100012_FETCH_UNIT -- requirements
Module: ysyx_24100012_fetch_unit

Interface
REQ-001 Parameters SHALL be: ADDR_WIDTH, 32, address width; DATA_WIDTH, 32, instruction width; ORIGIN_ADDR, 32'h80000000, reset PC; WORD_SIZE, 4, PC increment; BUF_DEPTH, 2, instruction buffer entries (power of two, >=2).
REQ-002 Ports SHALL be, in order:
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-low reset
- req_valid  out  1  memory fetch request valid
- req_ready  in  1  memory accepts request
- req_addr  out  ADDR_WIDTH  fetch address
- rsp_valid  in  1  memory response valid, one cycle per accepted request
- rsp_data  in  DATA_WIDTH  fetched instruction
- out_valid  out  1  instruction available to decode
- out_ready  in  1  decode consumes
- out_inst  out  DATA_WIDTH  instruction at buffer head
- out_pc  out  ADDR_WIDTH  PC of out_inst
- out_pc_next  out  ADDR_WIDTH  out_pc + WORD_SIZE
- redirect_valid  in  1  branch/jump taken, one-cycle pulse
- redirect_pc  in  ADDR_WIDTH  redirect target
- halt  in  1  stop issuing new fetches (ebreak seen)
- halted  out  1  halt latched and no request outstanding

Function
REQ-003 FSM states SHALL be IDLE, REQ, WAIT, DROP, HALT; at most one request outstanding.
REQ-004 IDLE->REQ when buffer has a free slot and halt not latched; IDLE->HALT when halt latched.
REQ-005 In REQ, req_valid=1 and req_addr=fetch_pc; req_addr SHALL be held stable until req_valid&&req_ready; on handshake go to WAIT.
REQ-006 In WAIT, on rsp_valid write {rsp_data, fetch_pc} into buffer, fetch_pc += WORD_SIZE (mod 2^ADDR_WIDTH), go to IDLE.
REQ-007 Redirect in IDLE/WAIT/REQ-with-handshake: flush buffer same cycle, fetch_pc <= redirect_pc; WAIT or handshaking REQ -> DROP, IDLE -> IDLE.
REQ-008 Redirect in REQ without handshake: request held unchanged, flush buffer, fetch_pc <= redirect_pc after acceptance; the resulting response SHALL be dropped (DROP).
REQ-009 In DROP, the next rsp_valid SHALL be discarded (not buffered), then go to IDLE; redirect in DROP updates fetch_pc only.
REQ-010 Buffer: FIFO of BUF_DEPTH; out_valid = !empty; pop on out_valid&&out_ready; simultaneous push and pop when full is not possible (no request issued when full); simultaneous push and pop otherwise keeps count.
REQ-011 Redirect and pop in the same cycle: flush wins, no pop effect.
REQ-012 Response arriving in same cycle as redirect in WAIT SHALL be discarded; FSM goes to IDLE, not DROP.
REQ-013 halt is sticky until reset; outstanding request completes (response buffered unless dropped); halted=1 in HALT; buffer still drains.
REQ-014 Latency: accepted request with rsp_valid next cycle -> out_valid next cycle after that; throughput one instruction per 3 cycles minimum.

Reset
REQ-015 While rst=0: state=IDLE, fetch_pc=ORIGIN_ADDR, buffer empty, halt latch clear, req_valid=0, out_valid=0, halted=0, out_inst=0, out_pc=ORIGIN_ADDR.
REQ-016 Reset asserted mid-request SHALL abandon it; first request after release goes to ORIGIN_ADDR; a late response from before reset is not expected and need not be handled.

Structure
REQ-017 FSM state encoding and WORD_SIZE/ORIGIN_ADDR defaults SHALL live in shared package ysyx_24100012_pkg.
REQ-018 Buffer SHALL be sub-module ysyx_24100012_sync_fifo (width DATA_WIDTH+ADDR_WIDTH, depth BUF_DEPTH, flush input).

Verification
REQ-019 Reset release, req_ready=1, rsp next cycle with 32'h00000013 -> req_addr 32'h80000000, then out_inst 32'h00000013, out_pc 32'h80000000, out_pc_next 32'h80000004.
REQ-020 out_ready=0 for 10 cycles -> exactly BUF_DEPTH(2) entries buffered, req_valid stays 0 after buffer full, PCs 80000000/80000004.
REQ-021 redirect_pc=32'h80000100 during WAIT -> response dropped, next req_addr 32'h80000100, no stale out_valid.
REQ-022 req_ready=0 for 5 cycles with redirect in cycle 2 -> req_addr held 32'h80000000 throughout, response dropped, next req 32'h80000100.
REQ-023 halt pulse during WAIT -> response buffered, no further req_valid, halted=1 after response.
REQ-024 fetch_pc=32'hFFFFFFFC via redirect -> following req_addr 32'h00000000.
